// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO decode values and cycle-counter width.
package mem_io_responder_pkg;

  localparam logic [1:0]  IO_SPACE     = 2'b11;
  localparam logic [31:0] IO_UART_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_CLK_ADDR  = 32'h0003_0004;
  localparam int          CYCLE_CNT_W  = 32;

endpackage

// File: rtl/io_tx_fifo.sv
// Power-of-two byte FIFO feeding the UART TX stream; a push at full is only taken alongside a pop.
module io_tx_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int            CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** DEPTH_LOG2);

  logic [7:0]            mem [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-facing RAM plus memory-mapped UART/clock IO. Define MEM_IO_CYCLE_CNT_EN to build the
// free-running cycle counter and its snapshot register behind 0x30004..0x30007.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 17,
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt
);

  localparam int            CW         = TX_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(2 ** TX_DEPTH_LOG2 - FULL_MARGIN);

  logic                     io_sel;
  logic                     uart_hit;
  logic                     clk_hit;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [7:0]               ram [2 ** RAM_ADDR_BITS];
  logic [7:0]               ram_q;
  logic                     sel_ram_q;
  logic [7:0]               io_q;
  logic [7:0]               io_rd_next;
  logic                     fifo_push;
  logic [7:0]               fifo_push_data;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic                     unused_addr_bits;

  assign unused_addr_bits = &{1'b0, cpu_a[31:18]};

  assign io_sel   = (cpu_a[17:16] == IO_SPACE);
  assign uart_hit = io_sel && (cpu_a[17:0] == IO_UART_ADDR[17:0]);
  assign clk_hit  = io_sel && (cpu_a[17:0] == IO_CLK_ADDR[17:0]);
  assign ram_addr = cpu_a[RAM_ADDR_BITS-1:0];

  // RAM is never reset; its registered output sits behind the cpu_din mux.
  always_ff @(posedge clk_in) begin
    if (cpu_wr && !io_sel) ram[ram_addr] <= cpu_dout;
    ram_q <= ram[ram_addr];
  end

`ifdef MEM_IO_CYCLE_CNT_EN
  logic                   clk_word_hit;
  logic [CYCLE_CNT_W-1:0] cycle_cnt;
  logic [CYCLE_CNT_W-1:0] snapshot;

  assign clk_word_hit = io_sel && (cpu_a[17:2] == IO_CLK_ADDR[17:2]);

  // Byte 0 is returned straight from the counter while the snapshot captures the same value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= '0;
      snapshot  <= '0;
    end else begin
      if (!halt) cycle_cnt <= cycle_cnt + CYCLE_CNT_W'(1);
      if (clk_hit && !cpu_wr) snapshot <= cycle_cnt;
    end
  end
`endif

  always_comb begin
    io_rd_next = 8'h00;
    if (!cpu_wr) begin
      if (uart_hit && rx_valid) io_rd_next = rx_data;
`ifdef MEM_IO_CYCLE_CNT_EN
      if (clk_word_hit) begin
        case (cpu_a[1:0])
          2'd0:    io_rd_next = cycle_cnt[7:0];
          2'd1:    io_rd_next = snapshot[15:8];
          2'd2:    io_rd_next = snapshot[23:16];
          default: io_rd_next = snapshot[31:24];
        endcase
      end
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_ram_q <= 1'b0;
      io_q      <= 8'h00;
    end else begin
      sel_ram_q <= !io_sel;
      io_q      <= io_rd_next;
    end
  end

  assign cpu_din = sel_ram_q ? ram_q : io_q;

  always_ff @(posedge clk_in) begin
    if (rst_in)                 halt <= 1'b0;
    else if (cpu_wr && clk_hit) halt <= 1'b1;
  end

  assign rx_pop = !rst_in && uart_hit && !cpu_wr && rx_valid;

  // A halt write doubles as an end-of-stream marker on the TX byte stream.
  assign fifo_push      = cpu_wr && (clk_hit || (uart_hit && (cpu_dout != 8'h00)));
  assign fifo_push_data = clk_hit ? 8'h00 : cpu_dout;

  io_tx_fifo #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (tx_valid && tx_ready),
    .head      (tx_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid       = !fifo_empty;
  assign io_buffer_full = (fifo_count >= FULL_LEVEL);

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder with read and TX-byte scoreboards.
module tb_mem_io_responder;

`ifdef MEM_IO_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        halt;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] cnt_model = 0;
  logic [31:0] snap_model = 0;
  bit          halt_model = 0;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_dout       (cpu_dout),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .halt           (halt)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // TX bytes are compared at the falling edge preceding the edge that pops them.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) checkOutput("tx_queue_nonempty", tx_q.size(), 1);
      else                  checkOutput("tx_byte", tx_data, tx_q.pop_front());
    end
  end

  function automatic logic [7:0] clkExp(input int b);
    logic [7:0] v;
    v = (b == 0) ? cnt_model[7:0] : snap_model[8*b +: 8];
    return CNT_EN ? v : 8'h00;
  endfunction

  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] data,
                               input bit check_rd, input logic [7:0] exp_rd);
    logic exp_pop;
    cpu_a    = addr;
    cpu_wr   = wr;
    cpu_dout = data;
    exp_pop  = (addr[17:0] == 18'h30000) && !wr && rx_valid;
    if (check_rd) rd_q.push_back(exp_rd);
    if (!wr && addr[17:0] == 18'h30004) snap_model = cnt_model;
    #1;
    checkOutput("rx_pop", rx_pop, exp_pop);
    @(posedge clk_in); #1;
    if (!halt_model) cnt_model++;
    if (wr && addr[17:0] == 18'h30004) halt_model = 1'b1;
    if (check_rd) checkOutput("cpu_din", cpu_din, rd_q.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic drainTx();
    int n = 0;
    while (tx_valid && n < 40) begin
      idle(1);
      n++;
    end
    checkOutput("tx_drained", tx_valid, 0);
    checkOutput("tx_queue_empty", tx_q.size(), 0);
  endtask

  task automatic doReset();
    tx_q.delete();
    rst_in   = 1'b1;
    cpu_a    = 32'h0003_0000;
    cpu_wr   = 1'b0;
    rx_valid = 1'b1;
    @(posedge clk_in); #1;
    checkOutput("rx_pop_in_reset", rx_pop, 0);
    @(posedge clk_in); #1;
    rst_in     = 1'b0;
    rx_valid   = 1'b0;
    cpu_a      = 32'h0;
    cnt_model  = 0;
    snap_model = 0;
    halt_model = 0;
    checkOutput("rst_cpu_din", cpu_din, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_io_full", io_buffer_full, 0);
    checkOutput("rst_halt", halt, 0);
    checkOutput("rst_rx_pop", rx_pop, 0);
  endtask

  initial begin
    cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rst_in = 1'b1;
    doReset();

    $display("[TB] RAM access");
    applyStimulus(32'h0000_0100, 1'b1, 8'hA5, 1'b0, 8'h00);
    applyStimulus(32'h0000_0100, 1'b0, 8'h00, 1'b1, 8'hA5);
    applyStimulus(32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00);
    applyStimulus(32'h0001_0100, 1'b1, 8'h11, 1'b0, 8'h00);
    applyStimulus(32'h0003_0100, 1'b1, 8'h77, 1'b0, 8'h00);
    applyStimulus(32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C);
    applyStimulus(32'h0001_0100, 1'b0, 8'h00, 1'b1, 8'h11);
    applyStimulus(32'h0000_0100, 1'b0, 8'h00, 1'b1, 8'hA5);
    applyStimulus(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00);

    $display("[TB] UART TX streaming");
    tx_ready = 1'b1;
    tx_q.push_back(8'h48);
    tx_q.push_back(8'h69);
    applyStimulus(32'h0003_0000, 1'b1, 8'h48, 1'b0, 8'h00);
    applyStimulus(32'h0003_0000, 1'b1, 8'h69, 1'b0, 8'h00);
    applyStimulus(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00);
    idle(3);
    drainTx();

    $display("[TB] TX back-pressure and overflow");
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) tx_q.push_back(8'(i));
      applyStimulus(32'h0003_0000, 1'b1, 8'(i), 1'b0, 8'h00);
      checkOutput("io_full", io_buffer_full, (i >= 6) ? 1 : 0);
    end
    checkOutput("tx_head_held", tx_data, 8'h01);
    tx_ready = 1'b1;
    tx_q.push_back(8'h0A);
    applyStimulus(32'h0003_0000, 1'b1, 8'h0A, 1'b0, 8'h00);
    checkOutput("io_full_push_pop", io_buffer_full, 1);
    drainTx();
    checkOutput("io_full_drained", io_buffer_full, 0);

    $display("[TB] UART RX reads");
    rx_valid = 1'b1; rx_data = 8'h33;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h33);
    applyStimulus(32'h0000_0100, 1'b0, 8'h00, 1'b1, 8'hA5);
    rx_valid = 1'b0; rx_data = 8'h5E;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);

    $display("[TB] cycle counter snapshot");
    doReset();
    idle(99);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, clkExp(0));
    applyStimulus(32'h0003_0005, 1'b0, 8'h00, 1'b1, clkExp(1));
    applyStimulus(32'h0003_0006, 1'b0, 8'h00, 1'b1, clkExp(2));
    applyStimulus(32'h0003_0007, 1'b0, 8'h00, 1'b1, clkExp(3));
    idle(200);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, clkExp(0));
    applyStimulus(32'h0003_0005, 1'b0, 8'h00, 1'b1, clkExp(1));

    $display("[TB] halt");
    tx_ready = 1'b1;
    tx_q.push_back(8'h00);
    applyStimulus(32'h0003_0004, 1'b1, 8'h5A, 1'b0, 8'h00);
    checkOutput("halt_set", halt, 1);
    idle(10);
    checkOutput("halt_sticky", halt, 1);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, clkExp(0));
    idle(5);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, clkExp(0));
    drainTx();
    doReset();
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, clkExp(0));
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b1, clkExp(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
